// File: rtl/nn_pkg.sv
// nn_pkg: definitions shared by the neuron multiply-accumulate blocks.
//   mac_state_e : sequencing states of neuron_mac
//   acc_width() : accumulator width that cannot overflow over a full neuron
//   q_saturate(): clamps a wide signed value into a signed q_size-bit range
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2
    } mac_state_e;

    // Widest value q_saturate accepts. The caller truncates the result to its own width.
    localparam int SAT_W = 128;

    // Full-precision products plus one growth bit per doubling of the element count.
    function automatic int acc_width(input int q_size, input int input_size);
        return 2 * q_size + $clog2(input_size);
    endfunction

    function automatic logic signed [SAT_W-1:0] q_saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      q_size
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (128'sd1 <<< (q_size - 1)) - 128'sd1;
        min_v = -(128'sd1 <<< (q_size - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/mac_datapath.sv
// mac_datapath: multiplier, accumulator, bias add, rescale, saturation and optional
// activation for one neuron.
// Optional feature macro: NEURON_MAC_RELU_EN (negative outputs replaced by zero).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear_i         : zero the accumulator (a new neuron is being accepted)
//   acc_en_i        : add serial_in_i * weight_in_i to the accumulator
//   bias_en_i       : add the bias, then register the output and pulse result_valid_o
//   serial_in_i     : signed activation
//   weight_in_i     : signed weight
//   bias_i          : signed bias
//   result_o        : signed, saturated neuron output (held between neurons)
//   result_valid_o  : one-cycle pulse when result_o updates
module mac_datapath
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE = 4,
    parameter int Q_SIZE     = 16,
    parameter int Q_FRAC     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     acc_en_i,
    input  logic                     bias_en_i,
    input  logic signed [Q_SIZE-1:0] serial_in_i,
    input  logic signed [Q_SIZE-1:0] weight_in_i,
    input  logic signed [Q_SIZE-1:0] bias_i,
    output logic signed [Q_SIZE-1:0] result_o,
    output logic                     result_valid_o
);

    localparam int ACC_W = acc_width(Q_SIZE, INPUT_SIZE);

    logic signed [2*Q_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [Q_SIZE-1:0]   sat_val;
    logic signed [Q_SIZE-1:0]   act_val;
    logic signed [Q_SIZE-1:0]   result_q;
    logic                       result_valid_q;

    // Operands are sign-extended to product width first so the multiply is full precision.
    assign prod     = (2*Q_SIZE)'(serial_in_i) * (2*Q_SIZE)'(weight_in_i);
    assign acc_d    = acc_q + ACC_W'(prod);

    // The bias is aligned to the product scale (2*Q_FRAC fraction bits) before adding.
    assign bias_ext = ACC_W'(bias_i) <<< Q_FRAC;
    assign sum      = acc_q + bias_ext;
    // An arithmetic shift floors toward minus infinity.
    assign shifted  = sum >>> Q_FRAC;
    assign sat_val  = Q_SIZE'(q_saturate(SAT_W'(shifted), Q_SIZE));

`ifdef NEURON_MAC_RELU_EN
    assign act_val  = sat_val[Q_SIZE-1] ? '0 : sat_val;
`else
    assign act_val  = sat_val;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            if (clear_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= acc_d;
            end
            result_valid_q <= bias_en_i;
            if (bias_en_i) begin
                result_q <= act_val;
            end
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: sequential fixed-point MAC neuron fed by an upstream serializer.
// Holds the FSM, element counter and control decode. Arithmetic is in mac_datapath.
// Optional feature macro: NEURON_MAC_RELU_EN (ReLU on the output, see mac_datapath).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; counter held at 0
//   ST_ACCUM | one element per cycle, weight_addr = counter
//   ST_BIAS  | add bias, rescale, saturate; result registered at the edge
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : begin one neuron (sampled in IDLE only)
//   serializer_update  : load the serializer (first ACCUM cycle)
//   serializer_shift   : advance the serializer (remaining ACCUM cycles)
//   serial_in          : signed activation
//   weight_addr        : weight index (0 outside ACCUM)
//   weight_in          : signed weight, combinational read of weight_addr
//   bias               : signed bias, used in the BIAS cycle
//   result             : signed saturated output
//   result_valid       : one-cycle pulse when result updates
//   busy               : high in ACCUM and BIAS
module neuron_mac
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE = 4,
    parameter int Q_SIZE     = 16,
    parameter int Q_FRAC     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          serializer_update,
    output logic                          serializer_shift,
    input  logic signed [Q_SIZE-1:0]      serial_in,
    output logic [$clog2(INPUT_SIZE)-1:0] weight_addr,
    input  logic signed [Q_SIZE-1:0]      weight_in,
    input  logic signed [Q_SIZE-1:0]      bias,
    output logic signed [Q_SIZE-1:0]      result,
    output logic                          result_valid,
    output logic                          busy
);

    localparam int CNT_W = $clog2(INPUT_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUT_SIZE - 1);

    mac_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             in_accum;
    logic             in_bias;

    assign in_accum = (state_q == ST_ACCUM);
    assign in_bias  = (state_q == ST_BIAS);
    assign accept   = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ACCUM;
                        cnt_q   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_BIAS;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BIAS: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign serializer_update = in_accum && (cnt_q == '0);
    assign serializer_shift  = in_accum && (cnt_q != '0);
    assign weight_addr       = in_accum ? cnt_q : '0;
    assign busy              = in_accum || in_bias;

    mac_datapath #(
        .INPUT_SIZE (INPUT_SIZE),
        .Q_SIZE     (Q_SIZE),
        .Q_FRAC     (Q_FRAC)
    ) u_datapath (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (accept),
        .acc_en_i       (in_accum),
        .bias_en_i      (in_bias),
        .serial_in_i    (serial_in),
        .weight_in_i    (weight_in),
        .bias_i         (bias),
        .result_o       (result),
        .result_valid_o (result_valid)
    );

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential fixed-point multiply-accumulate stage that sits directly downstream of the serializer. It drives the serializer's `serializer_update` and `serializer_shift` controls and consumes one Q-format activation per cycle on `serial_in`. Each activation is multiplied by the matching weight from an external asynchronous-read weight memory. After the last element the block adds a bias, rescales, saturates and emits one neuron output with a single-cycle valid pulse.

## Interface
- `INPUT_SIZE`, default 4: activations per neuron; must be ≥ 2.
- `Q_SIZE`, default 16: signed fixed-point word width.
- `Q_FRAC`, default 8: fractional bits; must be < `Q_SIZE`.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one neuron evaluation; sampled only in IDLE.
- `serializer_update` out 1: loads the serializer; high in the first ACCUM cycle only.
- `serializer_shift` out 1: advances the serializer; high in ACCUM cycles 2..`INPUT_SIZE`.
- `serial_in` in `Q_SIZE`: signed activation from the serializer.
- `weight_addr` out `$clog2(INPUT_SIZE)`: index of the current element.
- `weight_in` in `Q_SIZE`: signed weight; must reflect `weight_addr` in the same cycle (combinational read).
- `bias` in `Q_SIZE`: signed bias; sampled in the BIAS cycle.
- `result` out `Q_SIZE`: signed saturated neuron output; holds until the next result.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `busy` out 1: high in ACCUM and BIAS.

## Operation
- FSM states: IDLE, ACCUM, BIAS.
  - IDLE → ACCUM on `start`; the element counter and accumulator are cleared.
  - ACCUM → BIAS when counter = `INPUT_SIZE`-1.
  - BIAS → IDLE unconditionally.
- `serializer_update`, `serializer_shift`, `weight_addr` and `busy` are decoded combinationally from state and counter. `weight_addr` equals the counter in ACCUM and is 0 otherwise.
- Accumulator width ACC_W = 2·`Q_SIZE` + `$clog2(INPUT_SIZE)`, signed.
  - In each ACCUM cycle, add the sign-extended full-precision product `serial_in`·`weight_in`.
  - The accumulator cannot overflow.
- In BIAS, add `bias` sign-extended and shifted left by `Q_FRAC`. Then compute the output:
  - Arithmetic shift right by `Q_FRAC`, truncating toward −∞.
  - Saturate to [−2^(`Q_SIZE`−1), 2^(`Q_SIZE`−1)−1].
  - Apply the optional activation (see Configuration).
  - Register the value into `result` and pulse `result_valid`.
- `start` is ignored while `busy`; no queueing.
- Asynchronous reset (any state, including mid-ACCUM) forces:
  - state IDLE, counter 0, accumulator 0;
  - `result` 0, `result_valid` 0;
  - `serializer_update`/`serializer_shift` 0.

## Timing
- `start` is sampled high at edge 0.
- ACCUM occupies cycles 1..N (N = `INPUT_SIZE`); `serializer_update` is high in cycle 1.
- BIAS is cycle N+1.
- `result`/`result_valid` are visible in cycle N+2; `busy` is low in cycle N+2.
- Back-to-back: `start` high in cycle N+2 is accepted. Throughput is one neuron per N+2 cycles.
- Reset values: `busy`=0, `result_valid`=0, `result`=0, `weight_addr`=0, both serializer controls 0.

## Configuration
- `NEURON_MAC_RELU_EN` defined: a negative saturated value is replaced by 0 (ReLU).
- Undefined: the signed saturated value passes through unchanged.
- No other behaviour or timing changes.

## Structure
- Shared package `nn_pkg` holds:
  - the FSM state enum `mac_state_e`;
  - the saturation function `q_saturate(value, Q_SIZE)`;
  - the ACC_W width helper.
- One natural sub-module: `mac_datapath` (multiplier, accumulator, bias add, shift/saturate/activation). `neuron_mac` keeps the FSM, counter and control decode.

## Test plan
All scenarios use `INPUT_SIZE`=4, `Q_SIZE`=16, `Q_FRAC`=8.
- Basic: activations 0x0100 ×4, weights 0x0100, bias 0 → `result`=0x0400 with `result_valid` in cycle 6; `serializer_update` in cycle 1 only, shift in cycles 2–4, `weight_addr` 0,1,2,3.
- Saturation: activations/weights 0x7F00, bias 0x7FFF → 0x7FFF; activations 0x8000, weights 0x7FFF → 0x8000 (ReLU build: 0x0000).
- Negative and truncation: activations 0xFFFF, weights 0x0001, bias 0 → 0xFFFF (−1 after floor; ReLU build: 0x0000). Activations 0xFF00, weights 0x0100, bias 0x0080 → 0xFC80.
- Back-to-back: `start` held high → `result_valid` in cycles 6, 12, 18; `start` pulses during `busy` are ignored.
- Reset mid-op: assert `rst_n`=0 in cycle 3 → all outputs 0 immediately (asynchronous). Restart after release with the basic stimulus → 0x0400, with no residue from the aborted accumulation.
